// File: rtl/data_ram_arb_pkg.sv
// rtl/data_ram_arb_pkg.sv - shared types and defaults for the data RAM arbiter
package data_ram_arb_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - core/secondary arbiter for the single-port data RAM
module data_ram_arbiter
  import data_ram_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              cpu_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_d,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_tick,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_we,
  input  logic [DATA_W-1:0] b_d,
  output logic              b_gnt,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  output logic              ram_tick,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [CNT_W-1:0] FORCE_AT = CNT_W'(MAX_WAIT - 1);

  arb_state_e       state, state_nx;
  logic [CNT_W-1:0] wait_cnt, cnt_nx, cnt_inc;
  logic             core_own, grant, stall;

  always_comb begin
    core_own = tick & cpu_en & (state != FORCE);
    grant    = b_req & ~core_own;
    stall    = (state == FORCE) & b_req;
  end

  assign cpu_q    = ram_q;
  assign cpu_tick = tick & ~stall;
  assign b_gnt    = grant;
  assign ram_addr = grant ? b_addr : cpu_addr;
  assign ram_d    = grant ? b_d : cpu_d;
  assign ram_we   = core_own ? cpu_we : (grant & b_we);
  // The secondary port may write while the core is not stepping, so it drives its own strobe.
  assign ram_tick = grant | tick;

  assign cnt_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + CNT_W'(1);

  always_comb begin
    state_nx = state;
    cnt_nx   = wait_cnt;
    case (state)
      IDLE: begin
        if (b_req && !grant) begin
          state_nx = PEND;
          cnt_nx   = CNT_W'(1);
        end
      end
      PEND: begin
        if (grant || !b_req) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc;
          if (cnt_inc >= FORCE_AT) state_nx = FORCE;
        end
      end
      FORCE: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
    end else begin
      b_rvalid <= grant & ~b_we;
      if (grant && !b_we) b_rdata <= ram_q;
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb/tb_data_ram_arbiter.sv - self-checking bench for data_ram_arbiter
module tb_data_ram_arbiter;
  import data_ram_arb_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick, cpu_en, cpu_we, b_req, b_we;
  logic [AW-1:0] cpu_addr, b_addr, ram_addr;
  logic [DW-1:0] cpu_d, b_d, cpu_q, b_rdata, ram_d, ram_q;
  logic          cpu_tick, b_gnt, b_rvalid, ram_we, ram_tick;

  logic [DW-1:0] mem [1024];
  logic [DW-1:0] exp_q [$];
  int            checks = 0;
  int            errors = 0;

  logic          pend_q = 1'b0;
  logic [AW-1:0] pa;
  logic [DW-1:0] pd;
  logic          pw;

  typedef struct {
    string name;
    logic  tick, cpu_en, cpu_we, b_req, b_we;
    logic  gnt, rwe, rtick, ctick, selb;
  } vec_t;
  vec_t vecs [7];

  data_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .cpu_en(cpu_en),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_d(cpu_d), .cpu_q(cpu_q),
    .cpu_tick(cpu_tick), .b_req(b_req), .b_addr(b_addr), .b_we(b_we),
    .b_d(b_d), .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we),
    .ram_tick(ram_tick), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  assign ram_q = mem[ram_addr];
  always @(posedge clk) if (ram_tick && ram_we) mem[ram_addr] <= ram_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && b_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected: got %h expected none", b_rdata);
      end else begin
        chk("b_rdata", b_rdata, exp_q.pop_front());
      end
    end
  end

  // Held requests must keep address/data stable until granted.
  always @(posedge clk) begin
    if (pend_q && b_req && (b_addr != pa || b_d != pd || b_we != pw)) begin
      errors++;
      $display("FAIL protocol: request changed before grant addr %h expected %h", b_addr, pa);
    end
    pend_q = rst_n && b_req && !b_gnt;
    pa = b_addr;
    pd = b_d;
    pw = b_we;
  end

  task automatic clear_in();
    tick = 0; cpu_en = 0; cpu_we = 0; b_req = 0; b_we = 0;
    cpu_addr = '0; b_addr = '0; cpu_d = '0; b_d = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nst;
    vecs[0] = '{"all_low",      0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[1] = '{"core_wr",      1, 1, 1, 0, 0,  0, 1, 1, 1, 0};
    vecs[2] = '{"core_prio",    1, 1, 1, 1, 0,  0, 1, 1, 1, 0};
    vecs[3] = '{"b_rd_notick",  0, 1, 0, 1, 0,  1, 0, 1, 0, 1};
    vecs[4] = '{"b_wr_noen",    1, 0, 0, 1, 1,  1, 1, 1, 1, 1};
    vecs[5] = '{"cpu_we_noen",  1, 0, 1, 0, 0,  0, 0, 1, 1, 0};
    vecs[6] = '{"noreq_notick", 0, 1, 1, 0, 0,  0, 0, 0, 0, 0};

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h010] = 32'hDEADBEEF;
    mem[10'h030] = 32'hCAFEF00D;
    mem[10'h040] = 32'h11112222;

    clear_in();
    rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
    @(negedge clk);
    chk("rst_state",    32'(dut.state), 32'(IDLE));
    chk("rst_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    chk("rst_rvalid",   32'(b_rvalid), 32'd0);
    chk("rst_rdata",    b_rdata, 32'd0);
    chk("rst_gnt",      32'(b_gnt), 32'd0);
    chk("rst_ram_we",   32'(ram_we), 32'd0);
    chk("rst_cpu_tick", 32'(cpu_tick), 32'd0);

    // Combinational decode from IDLE; each vector is undone by reset before any edge.
    for (int i = 0; i < 7; i++) begin
      cyc();
      tick = vecs[i].tick; cpu_en = vecs[i].cpu_en; cpu_we = vecs[i].cpu_we;
      b_req = vecs[i].b_req; b_we = vecs[i].b_we;
      cpu_addr = 10'h100; b_addr = 10'h200; cpu_d = 32'h0C0C0C0C; b_d = 32'h0B0B0B0B;
      #1;
      chk({vecs[i].name, "_gnt"},   32'(b_gnt),    32'(vecs[i].gnt));
      chk({vecs[i].name, "_we"},    32'(ram_we),   32'(vecs[i].rwe));
      chk({vecs[i].name, "_rtick"}, 32'(ram_tick), 32'(vecs[i].rtick));
      chk({vecs[i].name, "_ctick"}, 32'(cpu_tick), 32'(vecs[i].ctick));
      chk({vecs[i].name, "_addr"},  32'(ram_addr), vecs[i].selb ? 32'h200 : 32'h100);
      chk({vecs[i].name, "_d"},     ram_d, vecs[i].selb ? 32'h0B0B0B0B : 32'h0C0C0C0C);
      #1 rst_n = 0;
      #1 rst_n = 1;
      clear_in();
    end

    // Idle secondary read
    cyc();
    b_req = 1; b_addr = 10'h010;
    @(negedge clk);
    chk("idle_rd_gnt", 32'(b_gnt), 32'd1);
    exp_q.push_back(32'hDEADBEEF);
    cyc();
    b_req = 0;
    @(negedge clk);
    chk("idle_rd_rvalid", 32'(b_rvalid), 32'd1);
    cyc();
    @(negedge clk);
    chk("idle_rd_rvalid_off", 32'(b_rvalid), 32'd0);

    // Core priority over a pending read
    cyc();
    tick = 1; cpu_en = 1; cpu_we = 1; cpu_addr = 10'h020; cpu_d = 32'h12345678;
    b_req = 1; b_addr = 10'h030; b_we = 0;
    @(negedge clk);
    chk("prio_gnt0", 32'(b_gnt), 32'd0);
    chk("prio_ram_we", 32'(ram_we), 32'd1);
    cyc();
    cpu_en = 0; cpu_we = 0;
    @(negedge clk);
    chk("prio_gnt1", 32'(b_gnt), 32'd1);
    chk("prio_cpu_wr", mem[10'h020], 32'h12345678);
    exp_q.push_back(32'hCAFEF00D);
    cyc();
    b_req = 0; tick = 0;

    // Starvation: forced grant on cycle MAX_WAIT only
    cyc();
    tick = 1; cpu_en = 1; b_req = 1; b_addr = 10'h040;
    for (int c = 1; c <= MW; c++) begin
      @(negedge clk);
      chk($sformatf("starve_gnt_c%0d", c), 32'(b_gnt), 32'(c == MW));
      chk($sformatf("starve_ctick_c%0d", c), 32'(cpu_tick), 32'(c != MW));
      if (c == MW) exp_q.push_back(32'h11112222);
      cyc();
      if (c == MW) b_req = 0;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("starve_resume_ctick", 32'(cpu_tick), 32'd1);
      chk("starve_resume_gnt", 32'(b_gnt), 32'd0);
      cyc();
    end

    // Secondary write in an idle cycle, then core readback
    clear_in();
    b_req = 1; b_we = 1; b_addr = 10'h3FF; b_d = 32'hA5A5A5A5;
    @(negedge clk);
    chk("bwr_gnt", 32'(b_gnt), 32'd1);
    chk("bwr_ram_tick", 32'(ram_tick), 32'd1);
    chk("bwr_ram_we", 32'(ram_we), 32'd1);
    cyc();
    clear_in();
    tick = 1; cpu_en = 1; cpu_addr = 10'h3FF;
    @(negedge clk);
    chk("bwr_rvalid", 32'(b_rvalid), 32'd0);
    chk("bwr_readback", cpu_q, 32'hA5A5A5A5);
    cyc();

    // Request withdrawn after three waits
    b_req = 1; b_addr = 10'h050;
    cyc(); cyc(); cyc();
    chk("wd_wait_cnt3", 32'(dut.wait_cnt), 32'd3);
    b_req = 0;
    cyc();
    chk("wd_state", 32'(dut.state), 32'(IDLE));
    chk("wd_wait_cnt0", 32'(dut.wait_cnt), 32'd0);
    nst = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!cpu_tick) nst++;
      cyc();
    end
    chk("wd_no_stall", 32'(nst), 32'd0);

    // Reset asserted mid-cycle while in FORCE
    b_req = 1; b_addr = 10'h060;
    for (int c = 0; c < MW - 1; c++) cyc();
    #2;
    chk("frc_state", 32'(dut.state), 32'(FORCE));
    chk("frc_stall", 32'(cpu_tick), 32'd0);
    rst_n = 0;
    #1;
    chk("frc_rst_ctick", 32'(cpu_tick), 32'd1);
    chk("frc_rst_gnt", 32'(b_gnt), 32'd0);
    chk("frc_rst_rvalid", 32'(b_rvalid), 32'd0);
    chk("frc_rst_rdata", b_rdata, 32'd0);
    b_req = 0;
    cyc();
    rst_n = 1;
    clear_in();
    cyc(); cyc();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
